mem_fifo_read_adapter: RTL and testbench

- Downstream consumer of the memory core in FIFO mode (mode=1, tile_en=1, chaining off).
- Tracks core occupancy from observed writes and its own reads, and issues ren_in only when data exists and output space is guaranteed.
- Absorbs the core's 1-cycle read latency in a 2-entry skid buffer and presents a valid/ready stream to the next stage (accelerator input or A-QED checker).
- Flags protocol violations with sticky error bits.

---
 rtl/mem_fifo_pkg.sv | 15 +
 rtl/mem_skid_buf.sv | 57 +++++
 rtl/mem_fifo_read_adapter.sv | 93 +++++++++
 tb/tb_mem_fifo_read_adapter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fifo_pkg.sv
// Shared constants and types for the memory-core FIFO read adapter.
package mem_fifo_pkg;
    localparam int unsigned DATA_WIDTH  = 16;
    localparam int unsigned OCC_WIDTH   = 17;
    localparam int unsigned DEPTH_WIDTH = 16;
    localparam int unsigned SKID_DEPTH  = 2;
    localparam int unsigned CNT_WIDTH   = 2;
    localparam int unsigned READ_LAT    = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;
endpackage

// File: rtl/mem_skid_buf.sv
// Two-entry in-order buffer absorbing the core read latency; entry0 is always the head.
module mem_skid_buf
    import mem_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clear,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     din,
    output logic [CNT_WIDTH-1:0] count,
    output logic [WIDTH-1:0]     head
);
    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;

    assign head = entry0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            entry0 <= '0;
            entry1 <= '0;
        end else if (en) begin
            if (clear) begin
                count  <= '0;
                entry0 <= '0;
                entry1 <= '0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        if (count == '0) entry0 <= din;
                        else             entry1 <= din;
                        count <= count + CNT_WIDTH'(1);
                    end
                    2'b01: begin
                        entry0 <= entry1;
                        count  <= count - CNT_WIDTH'(1);
                    end
                    2'b11: begin
                        // With one entry the new word becomes head; with two it queues behind entry1.
                        if (count == CNT_WIDTH'(1)) begin
                            entry0 <= din;
                        end else begin
                            entry0 <= entry1;
                            entry1 <= din;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: rtl/mem_fifo_read_adapter.sv
// Reads a FIFO-mode memory core on credit and presents its words as a valid/ready stream.
module mem_fifo_read_adapter
    import mem_fifo_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    input  logic                   flush,
    input  logic [DEPTH_WIDTH-1:0] depth,
    input  logic                   wen_in,
    output logic                   ren_out,
    input  logic [DATA_WIDTH-1:0]  core_data,
    input  logic                   core_valid,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [OCC_WIDTH-1:0]   occupancy,
    output logic                   err_overflow,
    output logic                   err_spurious
);
    state_t                 state;
    state_t                 state_d;
    logic                   inflight;
    logic [CNT_WIDTH-1:0]   skid_count;
    logic                   pop;
    logic                   push;
    logic                   credit_ok;
    logic                   ovf_c;
    logic                   spur_c;
    logic [OCC_WIDTH-1:0]   occ_d;

    assign m_valid = (skid_count != '0);
    assign pop     = m_valid & m_ready;

    // A read may only issue if its return is guaranteed a skid slot, counting a same-cycle pop.
    assign credit_ok = (3'(skid_count) + 3'(inflight)) <= (3'(SKID_DEPTH - 1) + 3'(pop));
    assign ren_out   = clk_en & ~flush & (occupancy != '0) & credit_ok;

    assign ovf_c  = wen_in & ~flush & (occupancy == OCC_WIDTH'(depth)) & ~ren_out;
    assign push   = core_valid & inflight & ~flush & (state != FLUSH);
    assign spur_c = core_valid & ~inflight & ~flush & (state != FLUSH);
    assign occ_d  = occupancy + OCC_WIDTH'(wen_in & ~ovf_c) - OCC_WIDTH'(ren_out);

    mem_skid_buf #(
        .WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (clk_en),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   (core_data),
        .count (skid_count),
        .head  (m_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            occupancy    <= '0;
            inflight     <= 1'b0;
            err_overflow <= 1'b0;
            err_spurious <= 1'b0;
        end else if (clk_en) begin
            state        <= state_d;
            err_overflow <= err_overflow | ovf_c;
            err_spurious <= err_spurious | spur_c;
            if (flush) begin
                occupancy <= '0;
                inflight  <= 1'b0;
            end else begin
                occupancy <= occ_d;
                inflight  <= ren_out;
            end
        end
    end

    // FLUSH holds one extra cycle so a read issued just before flush returns harmlessly.
    always_comb begin
        state_d = state;
        if (flush) begin
            state_d = FLUSH;
        end else begin
            case (state)
                IDLE:    if (occupancy != '0) state_d = STREAM;
                STREAM:  if (occupancy == '0 && skid_count == '0 && !inflight) state_d = IDLE;
                FLUSH:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_fifo_read_adapter.sv
// Directed bench for mem_fifo_read_adapter with a behavioural FIFO-mode memory core.
module tb_mem_fifo_read_adapter;
    import mem_fifo_pkg::*;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        flush;
    logic [15:0] depth;
    logic        wen_in;
    logic [15:0] wdata;
    logic        ren_out;
    logic        m_ready;
    logic        m_valid;
    logic [15:0] m_data;
    logic [16:0] occupancy;
    logic        err_overflow;
    logic        err_spurious;
    logic        spur;
    logic        cv_m;
    logic [15:0] cd_m;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          ren_cnt  = 0;
    logic [15:0] core_q[$];
    logic [15:0] exp_q[$];

    mem_fifo_read_adapter dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .flush        (flush),
        .depth        (depth),
        .wen_in       (wen_in),
        .ren_out      (ren_out),
        .core_data    (cd_m),
        .core_valid   (cv_m | spur),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .occupancy    (occupancy),
        .err_overflow (err_overflow),
        .err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory core in FIFO mode: one-cycle read latency, drops writes when full.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cv_m <= 1'b0;
            cd_m <= '0;
            core_q.delete();
        end else if (clk_en) begin
            cv_m <= ren_out;
            if (ren_out && core_q.size() > 0) cd_m <= core_q.pop_front();
            if (flush) core_q.delete();
            else if (wen_in && core_q.size() < int'(depth)) core_q.push_back(wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic w, input logic [15:0] d, input logic rdy);
        wen_in  = w;
        wdata   = d;
        m_ready = rdy;
        if (w && clk_en) exp_q.push_back(d);
        #1;
    endtask

    // Checks any stream handshake of the current cycle, then advances one clock.
    task automatic cyc();
        if (clk_en && m_valid && m_ready) begin
            chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
        if (ren_out) ren_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b1; flush = 1'b0; depth = 16'd4;
        wen_in = 1'b0; wdata = '0; m_ready = 1'b0; spur = 1'b0;
        #12;
        chk("rst_ren", 32'(ren_out), 32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_mdata", 32'(m_data), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_errs", 32'({err_overflow, err_spurious}), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        @(posedge clk); #1;
        reset = 1'b0;
        #1;

        // T1: four words streamed with ready high; first m_valid three cycles after first write
        drive(1'b1, 16'h11, 1'b1); chk("t1_ren_c0", 32'(ren_out), 32'd0); cyc();
        drive(1'b1, 16'h12, 1'b1); chk("t1_ren_c1", 32'(ren_out), 32'd1); cyc();
        drive(1'b1, 16'h13, 1'b1); chk("t1_mvalid_c2", 32'(m_valid), 32'd0); cyc();
        drive(1'b1, 16'h14, 1'b1); chk("t1_mvalid_c3", 32'(m_valid), 32'd1);
        chk("t1_first_data", 32'(m_data), 32'h11); cyc();
        drive(1'b0, 16'h0, 1'b1);
        run(6);
        chk("t1_all_out", 32'(exp_q.size()), 32'd0);
        chk("t1_occ", 32'(occupancy), 32'd0);
        chk("t1_mvalid_end", 32'(m_valid), 32'd0);
        chk("t1_state", 32'(dut.state), 32'(IDLE));
        chk("t1_errs", 32'({err_overflow, err_spurious}), 32'd0);

        // T2: backpressure bounds reads to the skid capacity, head stays stable
        ren_cnt = 0;
        drive(1'b1, 16'h11, 1'b0); cyc();
        drive(1'b1, 16'h12, 1'b0); cyc();
        drive(1'b1, 16'h13, 1'b0); cyc();
        drive(1'b1, 16'h14, 1'b0); cyc();
        drive(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("t2_hold_data", 32'(m_data), 32'h11);
            cyc();
        end
        chk("t2_ren_pulses", 32'(ren_cnt), 32'd2);
        chk("t2_mvalid", 32'(m_valid), 32'd1);
        chk("t2_occ", 32'(occupancy), 32'd2);
        drive(1'b0, 16'h0, 1'b1);
        run(10);
        chk("t2_all_out", 32'(exp_q.size()), 32'd0);
        chk("t2_occ_end", 32'(occupancy), 32'd0);

        // T3: write into a full core with no read possible flags overflow and saturates
        depth = 16'd2;
        drive(1'b1, 16'hA1, 1'b0); cyc();
        drive(1'b1, 16'hA2, 1'b0); cyc();
        drive(1'b1, 16'hA3, 1'b0); cyc();
        drive(1'b1, 16'hA4, 1'b0); cyc();
        drive(1'b1, 16'hA5, 1'b0);
        void'(exp_q.pop_back());
        chk("t3_occ_full", 32'(occupancy), 32'd2);
        chk("t3_ren_blocked", 32'(ren_out), 32'd0);
        chk("t3_err_pre", 32'(err_overflow), 32'd0);
        cyc();
        drive(1'b0, 16'h0, 1'b0);
        chk("t3_err_set", 32'(err_overflow), 32'd1);
        chk("t3_occ_sat", 32'(occupancy), 32'd2);
        run(2);
        chk("t3_err_sticky", 32'(err_overflow), 32'd1);
        drive(1'b0, 16'h0, 1'b1);
        run(10);
        chk("t3_all_out", 32'(exp_q.size()), 32'd0);
        chk("t3_occ_end", 32'(occupancy), 32'd0);
        depth = 16'd4;

        // T4: core_valid without a read in flight
        chk("t4_spur_pre", 32'(err_spurious), 32'd0);
        spur = 1'b1;
        drive(1'b0, 16'h0, 1'b1); cyc();
        spur = 1'b0;
        chk("t4_spur_set", 32'(err_spurious), 32'd1);
        chk("t4_mvalid", 32'(m_valid), 32'd0);
        cyc();
        chk("t4_mvalid_later", 32'(m_valid), 32'd0);
        chk("t4_occ", 32'(occupancy), 32'd0);

        // T5: flush with a word in skid and a read returning
        drive(1'b1, 16'hB1, 1'b0); cyc();
        drive(1'b1, 16'hB2, 1'b0); cyc();
        drive(1'b0, 16'h0, 1'b0); chk("t5_ren", 32'(ren_out), 32'd1); cyc();
        flush = 1'b1;
        drive(1'b0, 16'h0, 1'b0);
        chk("t5_skid_one", 32'(m_valid), 32'd1);
        chk("t5_ren_flush", 32'(ren_out), 32'd0);
        cyc();
        flush = 1'b0;
        exp_q.delete();
        drive(1'b0, 16'h0, 1'b1);
        chk("t5_mvalid", 32'(m_valid), 32'd0);
        chk("t5_occ", 32'(occupancy), 32'd0);
        chk("t5_state", 32'(dut.state), 32'(FLUSH));
        chk("t5_err_kept", 32'({err_overflow, err_spurious}), 32'd3);
        cyc();
        drive(1'b1, 16'hAA, 1'b1);
        chk("t5_idle", 32'(dut.state), 32'(IDLE));
        cyc();
        drive(1'b0, 16'h0, 1'b1);
        run(6);
        chk("t5_all_out", 32'(exp_q.size()), 32'd0);

        // T6: steady write+read at occupancy 1, then a three-cycle clock-enable freeze
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'(16'h30 + i), 1'b1);
            if (i >= 1) begin
                chk("t6_ren", 32'(ren_out), 32'd1);
                chk("t6_occ", 32'(occupancy), 32'd1);
            end
            if (i >= 3) chk("t6_mvalid", 32'(m_valid), 32'd1);
            cyc();
        end
        clk_en = 1'b0;
        drive(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("t6_frz_ren", 32'(ren_out), 32'd0);
            chk("t6_frz_occ", 32'(occupancy), 32'd1);
            chk("t6_frz_data", 32'(m_data), 32'h37);
            cyc();
        end
        clk_en = 1'b1;
        drive(1'b0, 16'h0, 1'b1);
        run(8);
        chk("t6_all_out", 32'(exp_q.size()), 32'd0);
        chk("t6_occ_end", 32'(occupancy), 32'd0);
        chk("t6_state", 32'(dut.state), 32'(IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
